// File: rtl/fsk_pkg.sv
// Shared types and default constants for the FSK modulator controller.
package fsk_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fsk_state_e;

  localparam int unsigned FSK_ADDR_W = 10;
  localparam int unsigned FSK_STEP0  = 1;
  localparam int unsigned FSK_STEP1  = 2;
  localparam int unsigned FSK_CNT_W  = 16;

endpackage

// File: rtl/fsk_phase_acc.sv
// Carrier phase accumulator: wraps naturally at 2^ADDR_W and holds while disabled.
module fsk_phase_acc
  import fsk_pkg::*;
#(
  parameter int unsigned ADDR_W = FSK_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic [ADDR_W-1:0] i_step,
  output logic [ADDR_W-1:0] o_addr
);

  logic [ADDR_W-1:0] r_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
    end else if (i_en) begin
      r_addr <= r_addr + i_step;
    end
  end

  assign o_addr = r_addr;

endmodule

// File: rtl/fsk_mod_ctrl.sv
// Binary FSK modulator controller: symbol timing, bit handshake and
// phase-continuous carrier ROM addressing.
module fsk_mod_ctrl
  import fsk_pkg::*;
#(
  parameter int unsigned ADDR_W   = FSK_ADDR_W,
  parameter int unsigned BAUD_DIV = 1024,
  parameter int unsigned STEP0    = FSK_STEP0,
  parameter int unsigned STEP1    = FSK_STEP1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              bit_ready,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              carrier_sel,
  output logic              busy,
  output logic              underrun
);

  localparam logic [FSK_CNT_W-1:0] CNT_LOAD = FSK_CNT_W'(BAUD_DIV - 1);
  localparam logic [FSK_CNT_W-1:0] CNT_ONE  = FSK_CNT_W'(1);

  fsk_state_e           r_state;
  fsk_state_e           w_state_nxt;
  logic [FSK_CNT_W-1:0] r_cnt;
  logic [FSK_CNT_W-1:0] w_cnt_nxt;
  logic                 r_sel;
  logic                 w_sel_nxt;
  logic                 r_underrun;
  logic                 w_underrun_nxt;
  logic                 w_cnt_zero;
  logic                 w_xfer;
  logic                 w_acc_en;
  logic [ADDR_W-1:0]    w_step;

  assign w_cnt_zero = (r_cnt == '0);
  assign bit_ready  = en && ((r_state == ST_IDLE) || w_cnt_zero);
  assign w_xfer     = bit_ready && bit_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_sel      <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_sel      <= w_sel_nxt;
      r_underrun <= w_underrun_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_sel_nxt      = r_sel;
    w_underrun_nxt = 1'b0;
    if (en) begin
      case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            w_sel_nxt   = bit_in;
            w_cnt_nxt   = CNT_LOAD;
            w_state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          if (!w_cnt_zero) begin
            w_cnt_nxt = r_cnt - CNT_ONE;
          end else if (w_xfer) begin
            // Next symbol starts on the same edge the last one ends: no gap.
            w_sel_nxt = bit_in;
            w_cnt_nxt = CNT_LOAD;
          end else begin
            w_state_nxt    = ST_IDLE;
            w_underrun_nxt = 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Step uses the select of the symbol being finished, so the last cycle of
  // a symbol still advances at that symbol's frequency.
  assign w_step   = r_sel ? ADDR_W'(STEP1) : ADDR_W'(STEP0);
  assign w_acc_en = en && (r_state == ST_RUN);

  fsk_phase_acc #(
    .ADDR_W(ADDR_W)
  ) u_phase_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_acc_en),
    .i_step(w_step),
    .o_addr(rom_addr)
  );

  assign carrier_sel = r_sel;
  assign busy        = (r_state == ST_RUN);
  assign underrun    = r_underrun;

endmodule

// File: tb/tb_fsk_mod_ctrl.sv
// Directed self-checking bench for fsk_mod_ctrl with BAUD_DIV=4, STEP0=1, STEP1=2.
module tb_fsk_mod_ctrl;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       bit_in;
  logic       bit_valid;
  logic       bit_ready;
  logic [9:0] rom_addr;
  logic       carrier_sel;
  logic       busy;
  logic       underrun;

  int unsigned n_checks;
  int unsigned n_errors;
  int unsigned n_cyc;

  fsk_mod_ctrl #(
    .ADDR_W  (10),
    .BAUD_DIV(4),
    .STEP0   (1),
    .STEP1   (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .rom_addr   (rom_addr),
    .carrier_sel(carrier_sel),
    .busy       (busy),
    .underrun   (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then compare all outputs 1 ns later.
  task automatic cyc(input int a, input logic s, input logic b, input logic u, input logic r);
    @(posedge clk);
    #1;
    n_cyc++;
    check($sformatf("c%0d_addr", n_cyc), rom_addr, a);
    check($sformatf("c%0d_sel", n_cyc), carrier_sel, s);
    check($sformatf("c%0d_busy", n_cyc), busy, b);
    check($sformatf("c%0d_unr", n_cyc), underrun, u);
    check($sformatf("c%0d_rdy", n_cyc), bit_ready, r);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    n_cyc     = 0;
    rst_n     = 1'b0;
    en        = 1'b0;
    bit_in    = 1'b0;
    bit_valid = 1'b0;

    // Reset state
    #1;
    check("rst_addr", rom_addr, 0);
    check("rst_sel", carrier_sel, 0);
    check("rst_busy", busy, 0);
    check("rst_unr", underrun, 0);
    check("rst_rdy_en0", bit_ready, 0);

    // Single bit 1, valid for one transfer, then underrun
    #12;
    rst_n     = 1'b1;
    en        = 1'b1;
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    #1;
    check("idle_rdy", bit_ready, 1);
    cyc(0, 1, 1, 0, 0);
    bit_valid = 1'b0;
    cyc(2, 1, 1, 0, 0);
    cyc(4, 1, 1, 0, 0);
    cyc(6, 1, 1, 0, 1);
    cyc(8, 1, 0, 1, 1);
    cyc(8, 1, 0, 0, 1);

    // Gapless stream 0,1,0
    bit_valid = 1'b1;
    bit_in    = 1'b0;
    cyc(8, 0, 1, 0, 0);
    cyc(9, 0, 1, 0, 0);
    cyc(10, 0, 1, 0, 0);
    cyc(11, 0, 1, 0, 1);
    bit_in = 1'b1;
    cyc(12, 1, 1, 0, 0);
    cyc(14, 1, 1, 0, 0);
    cyc(16, 1, 1, 0, 0);
    cyc(18, 1, 1, 0, 1);
    bit_in = 1'b0;
    cyc(20, 0, 1, 0, 0);
    cyc(21, 0, 1, 0, 0);
    cyc(22, 0, 1, 0, 0);
    cyc(23, 0, 1, 0, 1);
    bit_valid = 1'b0;
    cyc(24, 0, 0, 1, 1);
    cyc(24, 0, 0, 0, 1);

    // Valid held during cnt>0 with a changing bit: select holds until cnt=0
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    cyc(24, 1, 1, 0, 0);
    bit_in = 1'b0;
    cyc(26, 1, 1, 0, 0);
    cyc(28, 1, 1, 0, 0);
    cyc(30, 1, 1, 0, 1);
    cyc(32, 0, 1, 0, 0);
    bit_valid = 1'b0;
    cyc(33, 0, 1, 0, 0);
    cyc(34, 0, 1, 0, 0);
    cyc(35, 0, 1, 0, 1);
    cyc(36, 0, 0, 1, 1);
    cyc(36, 0, 0, 0, 1);

    // Wrap: stream bit-1 symbols from 36 up to 1020, then across 1023
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    repeat (493) @(posedge clk);
    #1;
    check("pre_wrap_addr", rom_addr, 1020);
    check("pre_wrap_busy", busy, 1);
    cyc(1022, 1, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(2, 1, 1, 0, 1);
    bit_valid = 1'b0;
    cyc(4, 1, 0, 1, 1);
    cyc(4, 1, 0, 0, 1);

    // Clock-enable freeze mid-symbol
    bit_valid = 1'b1;
    bit_in    = 1'b0;
    cyc(4, 0, 1, 0, 0);
    bit_valid = 1'b0;
    cyc(5, 0, 1, 0, 0);
    en = 1'b0;
    #1;
    check("en0_rdy", bit_ready, 0);
    cyc(5, 0, 1, 0, 0);
    cyc(5, 0, 1, 0, 0);
    cyc(5, 0, 1, 0, 0);
    en = 1'b1;
    cyc(6, 0, 1, 0, 0);
    cyc(7, 0, 1, 0, 1);
    cyc(8, 0, 0, 1, 1);
    cyc(8, 0, 0, 0, 1);

    // Asynchronous reset mid-symbol, first transfer right after release
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    cyc(8, 1, 1, 0, 0);
    bit_valid = 1'b0;
    cyc(10, 1, 1, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_addr", rom_addr, 0);
    check("arst_sel", carrier_sel, 0);
    check("arst_busy", busy, 0);
    check("arst_unr", underrun, 0);
    bit_valid = 1'b1;
    bit_in    = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    cyc(0, 0, 1, 0, 0);
    bit_valid = 1'b0;
    cyc(1, 0, 1, 0, 0);
    cyc(2, 0, 1, 0, 0);
    cyc(3, 0, 1, 0, 1);
    cyc(4, 0, 0, 1, 1);
    cyc(4, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
